// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS32 single-port memory arbiter:
// default address width, data word width and read-owner encoding.
package mips_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned WORD_W     = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

endpackage

// File: rtl/mips_mem_starve_ctr.sv
// Fetch starvation counter: counts consecutive denied eligible fetch cycles
// and raises promote once the count reaches STARVE_MAX.
module mips_mem_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic halted,
    input  logic if_gnt,
    output logic promote
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q;

    assign promote = (cnt_q == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (if_gnt || !if_req || halted) begin
            cnt_q <= '0;
        end else if (!promote) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter: loader > data > fetch, 1-cycle read return.
// Define MIPS_MEM_ARB_STARVE_GUARD_EN to promote fetch after STARVE_MAX denials.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halted,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [WORD_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [WORD_W-1:0] dm_rdata,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("STARVE_MAX must be at least 1");
    end

    logic   if_ok;
    logic   promote;
    owner_e owner_q;

    assign if_ok = if_req & ~halted;

`ifdef MIPS_MEM_ARB_STARVE_GUARD_EN
    mips_mem_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .halted  (halted),
        .if_gnt  (if_gnt),
        .promote (promote)
    );
`else
    assign promote = 1'b0;
`endif

    // A promoted fetch jumps ahead of data but never ahead of the loader.
    assign ld_gnt   = ld_req;
    assign if_gnt   = if_ok & ~ld_req & (~dm_req | promote);
    assign dm_gnt   = dm_req & ~ld_req & ~if_gnt;
    assign if_stall = if_req & ~if_gnt;

    always_comb begin
        mem_en    = ld_gnt | dm_gnt | if_gnt;
        mem_we    = ld_gnt | (dm_gnt & dm_we);
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_we ? dm_wdata : '0;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else if (if_gnt) begin
            owner_q <= OWN_IF;
        end else if (dm_gnt && !dm_we) begin
            owner_q <= OWN_DM;
        end else begin
            owner_q <= OWN_NONE;
        end
    end

    assign if_rvalid = (owner_q == OWN_IF);
    assign dm_rvalid = (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios plus random
// traffic compared every cycle against a priority/scoreboard model.
module tb_mips_mem_arbiter;
    import mips_mem_pkg::*;

    localparam int unsigned AW   = 10;
    localparam int unsigned SMAX = 4;

    logic          clk, rst, halted;
    logic          ld_req, ld_gnt;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata, dm_rdata;
    logic          if_req, if_gnt, if_rvalid, if_stall;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    mips_mem_arbiter #(
        .ADDR_W     (AW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .halted    (halted),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory macro seen by the DUT.
    logic [31:0] mem_arr [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: winner = first eligible requester in priority order.
    logic [31:0] ref_mem [0:1023];
    int          pend;        // 0 none, 1 fetch, 2 data
    logic [31:0] pend_data;
    int          starve;
    int          win;         // 0 none, 1 loader, 2 data, 3 fetch
    logic        promote_m;
    logic [AW-1:0] e_addr;

    always @(negedge clk) begin
        if (rst) begin
            pend   = 0;
            starve = 0;
        end
        cmp("if_rvalid", if_rvalid, pend == 1);
        cmp("dm_rvalid", dm_rvalid, pend == 2);
        cmp("if_rdata", if_rdata, (pend == 1) ? pend_data : 32'h0);
        cmp("dm_rdata", dm_rdata, (pend == 2) ? pend_data : 32'h0);

`ifdef MIPS_MEM_ARB_STARVE_GUARD_EN
        promote_m = (starve == SMAX);
`else
        promote_m = 1'b0;
`endif
        if (ld_req)                          win = 1;
        else if (promote_m && if_req && !halted) win = 3;
        else if (dm_req)                     win = 2;
        else if (if_req && !halted)          win = 3;
        else                                 win = 0;

        cmp("ld_gnt", ld_gnt, win == 1);
        cmp("dm_gnt", dm_gnt, win == 2);
        cmp("if_gnt", if_gnt, win == 3);
        cmp("if_stall", if_stall, if_req && win != 3);
        cmp("mem_en", mem_en, win != 0);
        cmp("mem_we", mem_we, win == 1 || (win == 2 && dm_we));
        e_addr = (win == 1) ? ld_addr : (win == 2) ? dm_addr : if_addr;
        if (win != 0) cmp("mem_addr", mem_addr, e_addr);
        if (win == 1) cmp("mem_wdata", mem_wdata, ld_wdata);
        if (win == 2 && dm_we) cmp("mem_wdata", mem_wdata, dm_wdata);

        pend = 0;
        if (win == 1) ref_mem[ld_addr] = ld_wdata;
        if (win == 2 && dm_we) ref_mem[dm_addr] = dm_wdata;
        if (win == 2 && !dm_we) begin pend = 2; pend_data = ref_mem[dm_addr]; end
        if (win == 3) begin pend = 1; pend_data = ref_mem[if_addr]; end

        if (win == 3 || !if_req || halted) starve = 0;
        else if (starve < SMAX) starve++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic ld_write(input logic [AW-1:0] a, input logic [31:0] d);
        step();
        ld_req = 1'b1; ld_addr = a; ld_wdata = d;
        look();
        cmp("ld_write_gnt", ld_gnt, 1'b1);
        step();
        ld_req = 1'b0;
    endtask

    int   gcnt, first;
    logic g_ld, g_dm, g_if;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_arr[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem_rdata = 32'h0;
        rst = 1'b1; halted = 1'b0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        if_req = 1'b0; if_addr = '0;
        pend = 0; pend_data = '0; starve = 0;

        repeat (2) look();
        cmp("rst_ld_gnt", ld_gnt, 1'b0);
        cmp("rst_dm_gnt", dm_gnt, 1'b0);
        cmp("rst_if_gnt", if_gnt, 1'b0);
        cmp("rst_rvalid", {dm_rvalid, if_rvalid}, 2'b00);
        cmp("rst_mem_en", mem_en, 1'b0);
        cmp("rst_mem_we", mem_we, 1'b0);
        cmp("rst_mem_addr", mem_addr, 32'h0);
        cmp("rst_rdata", dm_rdata | if_rdata, 32'h0);
        step();
        rst = 1'b0;

        // Loader write followed by fetch of the same word.
        step();
        ld_req = 1'b1; ld_addr = 10'd0; ld_wdata = 32'h2801000a;
        if_req = 1'b1; if_addr = 10'd0;
        look();
        cmp("boot_ld_gnt", ld_gnt, 1'b1);
        cmp("boot_if_gnt0", if_gnt, 1'b0);
        cmp("boot_if_stall", if_stall, 1'b1);
        step();
        ld_req = 1'b0;
        look();
        cmp("boot_if_gnt1", if_gnt, 1'b1);
        step();
        if_req = 1'b0;
        look();
        cmp("boot_if_rvalid", if_rvalid, 1'b1);
        cmp("boot_if_rdata", if_rdata, 32'h2801000a);

        ld_write(10'd2, 32'h00002222);
        ld_write(10'd3, 32'h33330003);

        // Three simultaneous requesters.
        step();
        ld_req = 1'b1; ld_addr = 10'd1; ld_wdata = 32'h11111111;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd2;
        if_req = 1'b1; if_addr = 10'd3;
        look();
        cmp("all3_c1", {ld_gnt, dm_gnt, if_gnt}, 3'b100);
        step();
        ld_req = 1'b0;
        look();
        cmp("all3_c2", {ld_gnt, dm_gnt, if_gnt}, 3'b010);
        step();
        dm_req = 1'b0;
        look();
        cmp("all3_c3", {ld_gnt, dm_gnt, if_gnt}, 3'b001);
        cmp("all3_dm_rvalid", dm_rvalid, 1'b1);
        cmp("all3_dm_rdata", dm_rdata, 32'h00002222);
        step();
        if_req = 1'b0;
        look();
        cmp("all3_if_rvalid", {if_rvalid, dm_rvalid}, 2'b10);
        cmp("all3_if_rdata", if_rdata, 32'h33330003);

        // Halted: fetch blocked, loader and data keep working.
        step();
        halted = 1'b1; if_req = 1'b1; if_addr = 10'd4;
        ld_req = 1'b1; ld_addr = 10'd7; ld_wdata = 32'hcafe0007;
        for (int c = 0; c < 10; c++) begin
            look();
            cmp("halt_if_gnt", if_gnt, 1'b0);
            cmp("halt_if_stall", if_stall, 1'b1);
            if (c == 0) cmp("halt_ld_gnt", ld_gnt, 1'b1);
            if (c == 2) cmp("halt_dm_gnt", dm_gnt, 1'b1);
            if (c == 3) begin
                cmp("halt_dm_rvalid", dm_rvalid, 1'b1);
                cmp("halt_dm_rdata", dm_rdata, 32'hcafe0007);
            end
            step();
            ld_req = 1'b0;
            dm_req = (c + 1 == 2); dm_we = 1'b0; dm_addr = 10'd7;
        end
        halted = 1'b0; if_req = 1'b0; dm_req = 1'b0;

        // Continuous data traffic against a waiting fetch.
        gcnt = 0; first = -1;
        step();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd9;
        if_req = 1'b1; if_addr = 10'd10;
        for (int c = 1; c <= 8; c++) begin
            look();
            g_if = if_gnt;
            if (g_if) begin
                gcnt++;
                if (first < 0) first = c;
            end
            step();
            if (g_if) if_req = 1'b0;
        end
`ifdef MIPS_MEM_ARB_STARVE_GUARD_EN
        cmp("starve_gnt_count", gcnt, 1);
        cmp("starve_gnt_cycle", first, 5);
`else
        cmp("starve_gnt_count", gcnt, 0);
`endif
        dm_req = 1'b0; if_req = 1'b0;

        // Data write then read back-to-back.
        step();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd8; dm_wdata = 32'hfc000000;
        look();
        cmp("wr_dm_gnt", dm_gnt, 1'b1);
        cmp("wr_mem_we", mem_we, 1'b1);
        step();
        dm_we = 1'b0;
        look();
        cmp("rd_dm_gnt", dm_gnt, 1'b1);
        cmp("wr_no_rvalid", dm_rvalid, 1'b0);
        step();
        dm_req = 1'b0;
        look();
        cmp("rd_dm_rvalid", dm_rvalid, 1'b1);
        cmp("rd_dm_rdata", dm_rdata, 32'hfc000000);

        // Reset while a read is in flight.
        step();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd5;
        look();
        cmp("rstrd_dm_gnt", dm_gnt, 1'b1);
        #1;
        rst = 1'b1; dm_req = 1'b0;
        look();
        cmp("rstrd_no_rvalid0", dm_rvalid, 1'b0);
        step();
        rst = 1'b0;
        look();
        cmp("rstrd_no_rvalid1", dm_rvalid, 1'b0);

        // Random traffic; requesters hold until granted.
        g_ld = 1'b0; g_dm = 1'b0; g_if = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!ld_req || g_ld) begin
                ld_req   = ($urandom_range(0, 9) == 0);
                ld_addr  = 10'($urandom_range(0, 15));
                ld_wdata = $urandom;
            end
            if (!dm_req || g_dm) begin
                dm_req   = ($urandom_range(0, 9) < 4);
                dm_we    = $urandom_range(0, 1) == 1;
                dm_addr  = 10'($urandom_range(0, 15));
                dm_wdata = $urandom;
            end
            if (!if_req || g_if) begin
                if_req  = ($urandom_range(0, 9) < 6);
                if_addr = 10'($urandom_range(0, 15));
            end
            halted = ($urandom_range(0, 15) == 0);
            look();
            g_ld = ld_gnt; g_dm = dm_gnt; g_if = if_gnt;
        end

        step();
        ld_req = 1'b0; dm_req = 1'b0; if_req = 1'b0; halted = 1'b0;
        repeat (2) look();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Single-port memory arbiter for the pipelined MIPS32 core. Shares one synchronous word-addressed memory array (1-cycle read latency) between three requesters: program loader (write-only), MEM-stage data port (load/store) and IF-stage instruction fetch. Sits between the pipeline stages and the memory macro. Its stall indication lets the pipeline freeze IF when fetch loses arbitration.

## Interface
- `ADDR_W`, 10: word-address width (1024 x 32-bit words)
- `STARVE_MAX`, 4: consecutive denied fetch cycles before fetch is promoted (guard build only)

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `halted` in 1: core HALTED flag; blocks fetch grants
- `ld_req` in 1, `ld_addr` in ADDR_W, `ld_wdata` in 32: loader write request
- `ld_gnt` out 1: loader write accepted this cycle
- `dm_req` in 1, `dm_we` in 1, `dm_addr` in ADDR_W, `dm_wdata` in 32: data-port request
- `dm_gnt` out 1, `dm_rvalid` out 1, `dm_rdata` out 32: data grant, read return
- `if_req` in 1, `if_addr` in ADDR_W: fetch request (read only)
- `if_gnt` out 1, `if_rvalid` out 1, `if_rdata` out 32: fetch grant, read return
- `if_stall` out 1: `if_req & ~if_gnt`
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out 32: memory command
- `mem_rdata` in 32: memory read data, valid the cycle after an enabled read

## Operation
- Requesters hold `*_req` and payload stable until the matching `*_gnt`; `*_gnt` asserted for exactly one cycle per access.
- Fixed priority: loader > data > fetch. At most one grant per cycle.
- Fetch eligible only when `halted=0`. With `halted=1`: `if_gnt=0`, `if_stall=if_req`. Loader and data unaffected.
- Winner's command drives `mem_*` combinationally; `mem_en=1` iff a grant is issued; `mem_we=1` for loader grant or data grant with `dm_we=1`.
- Read owner register (none/IF/DM) captured on a granted read; next cycle the owner's `*_rvalid=1`, `*_rdata=mem_rdata`. Non-owner rdata = 0.
- Writes produce no rvalid.
- Reset mid-operation: owner register cleared; an in-flight read is dropped (no rvalid after reset).

## Timing
- Grant latency: 0 cycles (same cycle as request, if winning).
- Read data: `*_rvalid` exactly 1 cycle after `*_gnt`; back-to-back reads by any mix of requesters every cycle, rvalid pipelined with no bubbles.
- Simultaneous req from all three: `ld_gnt` only; data then fetch served on later cycles once higher requests drop.
- Reset values: all `*_gnt`, `*_rvalid`, `mem_en`, `mem_we` = 0; `*_rdata`, `mem_addr`, `mem_wdata` = 0; `if_stall` follows `if_req` (combinational); starvation counter = 0.
- Address wrap: none; `ADDR_W` bits passed unmodified.

## Configuration
- `MIPS_MEM_ARB_STARVE_GUARD_EN` defined: saturating counter increments each cycle `if_req & ~halted & ~if_gnt`; cleared on `if_gnt`, on `if_req=0` or on `halted=1`. When counter == `STARVE_MAX`, fetch outranks data (loader still highest); counter clears on the resulting grant.
- Undefined: pure fixed priority; fetch may starve indefinitely under continuous data traffic; `STARVE_MAX` unused.

## Structure
- Shared package `mips_mem_pkg`: `ADDR_W` default, owner enum (`OWN_NONE`, `OWN_IF`, `OWN_DM`), `WORD_W=32`.
- One sub-module `mips_mem_starve_ctr` (counter + promote flag), instantiated only under `MIPS_MEM_ARB_STARVE_GUARD_EN`.

## Test plan
- Reset, no requests -> all grants/rvalid/mem_en 0; assert `rst` mid-read (dm read addr 5 granted) -> no `dm_rvalid` afterwards.
- Loader writes 0x2801000a to addr 0, then fetch reads addr 0 -> `if_gnt` next cycle after `ld_req` drops, `if_rvalid=1` with `if_rdata=0x2801000a` one cycle later.
- All three request same cycle (ld addr 1, dm read addr 2, if addr 3) -> ld, dm, if granted on consecutive cycles; dm/if rvalid each 1 cycle after own grant.
- `halted=1` with `if_req=1` for 10 cycles -> `if_gnt=0`, `if_stall=1`; dm read addr 7 still granted, returns stored value.
- Guard build, `dm_req` held continuously with `if_req=1` -> `if_gnt` on cycle 5 (after 4 denials), then data resumes; non-guard build -> `if_gnt` never while `dm_req=1`.
- Data write 0xfc000000 to addr 8 then data read addr 8 back-to-back -> `dm_rvalid` only for the read, `dm_rdata=0xfc000000`.
